// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM state and prefetch queue entry type
// Used by fetch_sequencer_if, fetch_queue and fetch_sequencer.
package fetch_pkg;

    localparam int INSTR_W            = 32;
    localparam int ADDR_W             = 32;
    localparam int IMEM_BYTES_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] code;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory, redirect and decode handshake bundle
// master: fetch_sequencer side (drives imem_addr and the inst_* outputs).
// slave : environment side (drives imem_data, redirect_*, inst_ready).
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) ();

    logic [ADDR_W-1:0]      imem_addr;
    logic [INSTR_W-1:0]     imem_data;
    logic                   redirect_valid;
    logic [ADDR_W-1:0]      redirect_pc;
    logic                   inst_valid;
    logic                   inst_ready;
    logic [INSTR_W-1:0]     inst_code;
    logic [ADDR_W-1:0]      inst_pc;
    logic [$clog2(DEPTH):0] queue_count;
    logic                   fetch_fault;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_code,
        output inst_pc,
        output queue_count,
        output fetch_fault
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_code,
        input  inst_pc,
        input  queue_count,
        input  fetch_fault
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO with push, pop and flush
// Ports: clk, reset (async, active-high), push/push_data, pop, flush,
//        head (entry at read pointer), count (0..DEPTH), full, empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue can still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Any pop this cycle is implicitly complete; everything is discarded.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller with prefetch queue and redirect
// Ports: clk, reset (async, active-high), bus (fetch_sequencer_if.master).
// Optional feature: define FETCH_BOUNDS_CHECK_EN to fault on fetches past
// IMEM_BYTES-4 instead of wrapping the address.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                IMEM_BYTES = IMEM_BYTES_DEFAULT,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    fetch_entry_t      fetch_entry;
    fetch_entry_t      head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              pop;
    logic              fetch_try;
    logic              push;
    logic              out_of_range;
    logic              going_full;
    logic              unused_redirect_lsbs;

    assign pop       = !empty && bus.inst_ready;
    // Redirect wins: no fetch in the cycle the queue is flushed.
    assign fetch_try = (state != FAULT) && !bus.redirect_valid && (!full || pop);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(IMEM_BYTES - 4);
    assign out_of_range    = (fetch_pc > LAST_WORD);
    assign bus.imem_addr   = fetch_pc;
    assign bus.fetch_fault = (state == FAULT);
`else
    assign out_of_range    = 1'b0;
    assign bus.imem_addr   = fetch_pc & ADDR_W'(IMEM_BYTES - 1);
    assign bus.fetch_fault = 1'b0;
`endif

    assign push        = fetch_try && !out_of_range;
    assign fetch_entry = '{pc: fetch_pc, code: bus.imem_data};
    assign going_full  = full || (push && (count == CW'(DEPTH - 1)));

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (fetch_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.inst_valid  = !empty;
    assign bus.inst_code   = head.code;
    assign bus.inst_pc     = head.pc;
    assign bus.queue_count = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            state    <= RUN;
            fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            // FAULT is left only through redirect or reset.
            if (state != FAULT) begin
                if (fetch_try && out_of_range) begin
                    state <= FAULT;
                end else if (pop) begin
                    state <= RUN;
                end else if (going_full) begin
                    state <= HOLD;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller that drives the byte-addressed instruction memory's address port, captures each 32-bit instruction word into a small prefetch queue, and hands instructions to decode with a valid/ready handshake. It sits between the PC/branch logic and the first pipeline stage. It absorbs decode back-pressure and performs queue flushes and PC redirects on taken branches.

## Interface
Parameters:
- IMEM_BYTES, 32, instruction memory size in bytes; power of two, ≥ 8
- DEPTH, 4, prefetch queue entries; power of two, ≥ 2
- RESET_PC, 32'h0, fetch address after reset; word-aligned

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_addr  out  32  byte address to instruction memory (PC input)
- imem_data  in  32  instruction word from memory; combinational w.r.t. imem_addr
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  target byte address; bits [1:0] ignored (forced 0)
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst_code  out  32  head instruction word
- inst_pc  out  32  byte address of head instruction
- queue_count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
- fetch_fault  out  1  out-of-range fetch; sticky (FETCH_BOUNDS_CHECK_EN only; tied 0 otherwise)

## Operation
- Registers: fetch_pc (32 b), queue of DEPTH × {pc[31:0], code[31:0]}, count, state.
- States: RUN (fetching), HOLD (queue full, no fetch), FAULT (macro builds only; no fetch).
- imem_addr = fetch_pc & (IMEM_BYTES-1) without the macro; with the macro, imem_addr = fetch_pc.
- Pop: inst_valid & inst_ready; head advances.
- Fetch condition:
  - state ≠ FAULT;
  - no redirect;
  - count < DEPTH, or count == DEPTH with a pop in the same cycle.
- On fetch: enqueue {fetch_pc, imem_data}; fetch_pc ← fetch_pc + 4 (mod 2^32).
- Transitions:
  - RUN → HOLD when count reaches DEPTH with no pop.
  - HOLD → RUN on any pop.
  - Any state → RUN on redirect.
- Redirect priority over everything else:
  - A pop in the same cycle still completes, so decode has consumed the head.
  - Then all entries are discarded: count ← 0, and no enqueue that cycle.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
- Simultaneous fetch and pop: count unchanged.
- inst_valid = (count ≠ 0). inst_code and inst_pc come from the head entry and must be stable while inst_valid is high and inst_ready is low.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, count = 0, state = RUN.
  - inst_valid = 0, inst_code = 0, inst_pc = 0, fetch_fault = 0.
  - imem_addr = RESET_PC (masked as above).
- Fetch latency: the word at imem_addr is enqueued at the next rising edge, and inst_valid rises right after that edge. This gives one instruction per cycle at steady state.
- Redirect: asserted during cycle k, so imem_addr = target during cycle k+1 and inst_valid for the target follows edge k+1. This is exactly one bubble cycle.
- Reset asserted mid-operation drops inst_valid asynchronously. Any queued entries are lost.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - A fetch with fetch_pc > IMEM_BYTES-4 does not enqueue.
  - State moves to FAULT and fetch_fault = 1.
  - Queued entries still drain normally.
  - Only redirect or reset clears FAULT and fetch_fault.
- FETCH_BOUNDS_CHECK_EN undefined:
  - The address wraps modulo IMEM_BYTES, so the PC after IMEM_BYTES-4 fetches byte 0.
  - inst_pc carries the unwrapped fetch_pc.
  - fetch_fault is constant 0; there is no FAULT state.

## Structure
- Package fetch_pkg holds:
  - INSTR_W = 32 and ADDR_W = 32;
  - the fetch_state_t enum {RUN, HOLD, FAULT};
  - the queue entry struct {pc, code};
  - the default IMEM_BYTES.
- One sub-module, fetch_queue: a parameterised synchronous FIFO with push, pop and flush, plus count, full and empty outputs. The flush clears the FIFO when asserted together with pop.
- The top level contains the PC register, the FSM and the address masking/bounds logic.

## Test plan
- Reset, then hold inst_ready = 1 → inst_pc sequence 0, 4, 8, 12, 16 on consecutive cycles, with inst_code matching memory words 8C41000A, AC610005, ….
- Hold inst_ready = 0 → queue_count climbs to 4, state HOLD, imem_addr stays at 16. Release → one pop per cycle, with fetching resuming in the same cycle.
- Redirect to 32'h0000000E while 3 entries are queued and inst_ready = 1:
  - the head is consumed;
  - queue_count = 0 next cycle;
  - imem_addr = 12;
  - the next inst_pc = 12 after one bubble.
- No macro, IMEM_BYTES = 32 → after inst_pc 28 comes inst_pc 32 with the word read from address 0.
- Macro defined, fetch reaches pc 32:
  - fetch_fault = 1, with nothing enqueued for pc 32;
  - the earlier entries drain;
  - a redirect to 0 clears the fault and fetching resumes.
- Assert reset while the queue is full → inst_valid = 0 and queue_count = 0 without waiting for a clock edge. After release, the first inst_pc = RESET_PC.
